axi_lite_master: RTL

- Single-outstanding AXI4-Lite master bridging a simple user command/response port onto the AW/W/B/AR/R channels.
- Sits directly upstream of the AXI-Lite memory slave and drives its bus.
- The user issues one read or write command at a time and receives exactly one response pulse per command.

---
 rtl/axi_lite_master.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite master behind a user command/response port
//
// Accepts one read or write command at a time on the cmd_* port, runs it on the
// AW/W/B or AR/R channels and returns exactly one rsp_valid pulse per command.
// Every output is registered, so nothing on the bus depends combinationally on
// a READY/VALID input and everything reads 0 while ARESET is low.
//
// Ports:
//   ACLK, ARESET             clock, asynchronous active-low reset
//   cmd_valid/write/addr/wdata/wstrb, cmd_ready
//                            user command (accepted when valid & ready)
//   rsp_valid/rdata/resp/timeout
//                            one-cycle response pulse, payload held between pulses
//   AW*/W*/B*/AR*/R*         AXI4-Lite master channels
//
// Optional build macro AXI_MASTER_TIMEOUT_EN adds a watchdog that aborts a
// transaction after TIMEOUT busy cycles with rsp_timeout=1, rsp_resp=2'b10.

module axi_lite_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                cmd_valid,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                cmd_ready,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic                rsp_timeout,
   output logic                AWVALID,
   output logic [ADDR_W-1:0]   AWADDR,
   input  logic                AWREADY,
   output logic                WVALID,
   output logic [DATA_W-1:0]   WDATA,
   output logic [DATA_W/8-1:0] WSTRB,
   input  logic                WREADY,
   input  logic                BVALID,
   input  logic [1:0]          BRESP,
   output logic                BREADY,
   output logic                ARVALID,
   output logic [ADDR_W-1:0]   ARADDR,
   input  logic                ARREADY,
   input  logic                RVALID,
   input  logic [DATA_W-1:0]   RDATA,
   input  logic [1:0]          RRESP,
   output logic                RREADY
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic              cmd_ready_q, cmd_ready_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        rsp_resp_q, rsp_resp_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;

   logic accept;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic tmo_hit;

   assign accept = cmd_ready_q & cmd_valid;
   assign aw_hs  = awvalid_q & AWREADY;
   assign w_hs   = wvalid_q & WREADY;
   assign b_hs   = bready_q & BVALID;
   assign ar_hs  = arvalid_q & ARREADY;
   assign r_hs   = rready_q & RVALID;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              busy;

   assign busy    = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_DATA);
   // Hit on the edge where the count would reach TIMEOUT: exactly TIMEOUT busy cycles.
   assign tmo_hit = busy && (wdog_q == WDOG_W'(TIMEOUT - 1));

   always_comb begin
      wdog_d        = wdog_q;
      rsp_timeout_d = rsp_timeout_q;
      if (accept) begin
         wdog_d = '0;
      end else if (busy) begin
         wdog_d = wdog_q + 1'b1;
      end
      if (state_d == RSP) begin
         rsp_timeout_d = tmo_hit;
      end
   end

   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         wdog_q        <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         wdog_q        <= wdog_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign rsp_timeout = rsp_timeout_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT != 0);
   assign tmo_hit        = 1'b0;
   assign rsp_timeout    = 1'b0;
`endif

   // State register
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = cmd_write ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            if (tmo_hit) begin
               state_d = RSP;
            end else if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (tmo_hit || b_hs) begin
               state_d = RSP;
            end
         end
         RD_REQ: begin
            if (tmo_hit) begin
               state_d = RSP;
            end else if (ar_hs) begin
               state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            if (tmo_hit || r_hs) begin
               state_d = RSP;
            end
         end
         RSP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: outputs are decoded from the next state and registered, so
   // they line up with state_q while still reading 0 during reset.
   always_comb begin
      aw_done_d = accept ? 1'b0 : (aw_done_q | aw_hs);
      w_done_d  = accept ? 1'b0 : (w_done_q | w_hs);

      cmd_ready_d = (state_d == IDLE);
      awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
      wvalid_d    = (state_d == WR_REQ) && !w_done_d;
      bready_d    = (state_d == WR_RESP);
      arvalid_d   = (state_d == RD_REQ);
      rready_d    = (state_d == RD_DATA);
      rsp_valid_d = (state_d == RSP);

      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      if (state_d == RSP) begin
         if (tmo_hit) begin
            rsp_rdata_d = '0;
            rsp_resp_d  = 2'b10;
         end else if (state_q == WR_RESP) begin
            rsp_rdata_d = '0;
            rsp_resp_d  = BRESP;
         end else begin
            rsp_rdata_d = RDATA;
            rsp_resp_d  = RRESP;
         end
      end

      addr_d  = accept ? cmd_addr  : addr_q;
      wdata_d = accept ? cmd_wdata : wdata_q;
      wstrb_d = accept ? cmd_wstrb : wstrb_q;
   end

   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
      end else begin
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;
   assign AWVALID   = awvalid_q;
   assign AWADDR    = addr_q;
   assign WVALID    = wvalid_q;
   assign WDATA     = wdata_q;
   assign WSTRB     = wstrb_q;
   assign BREADY    = bready_q;
   assign ARVALID   = arvalid_q;
   assign ARADDR    = addr_q;
   assign RREADY    = rready_q;

endmodule
